// File: rtl/router_pkg.sv
// Shared definitions for the ipv4_router slice.
//   - header byte offsets (Ethernet + IPv4, no preamble/FCS)
//   - FSM state and destination encodings
//   - checksum helper used when ROUTER_TTL_DEC_EN is defined
package router_pkg;

  localparam int HDR_LEN  = 34;
  localparam int OFF_DMAC = 0;
  localparam int OFF_SMAC = 6;
  localparam int OFF_TYPE = 12;
  localparam int OFF_VER  = 14;
  localparam int OFF_TTL  = 22;
  localparam int OFF_CSUM = 24;
  localparam int OFF_DIP  = 30;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  FIB_NO_ROUTE   = 4'hF;

  typedef enum logic [2:0] {SYNC, IDLE, HDR, LOOKUP, WAIT, EMIT, BODY, DROP} state_t;

  // PORTn codes equal n in their low two bits; the steering mux relies on it.
  typedef enum logic [2:0] {PORT0, PORT1, PORT2, PORT3, NIC, NONE} dest_t;

  // Incremental checksum update for a TTL decrement: +0x0100, end-around carry.
  function automatic logic [15:0] csum_ttl_dec(input logic [15:0] csum);
    logic [16:0] sum;
    sum = {1'b0, csum} + 17'h00100;
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

endpackage

// File: rtl/ipv4_router_if.sv
// FIB lookup handshake between the router (master) and the FIB (slave).
//   req/search_ip : lookup request, held until ack
//   ack           : one-cycle response strobe
//   dest_ip       : echoed looked-up address
//   src_mac/dest_mac/forward_port : lookup result, valid with ack
interface ipv4_router_if;
  logic        req;
  logic [31:0] search_ip;
  logic        ack;
  logic [31:0] dest_ip;
  logic [47:0] src_mac;
  logic [47:0] dest_mac;
  logic [3:0]  forward_port;

  modport master (output req, search_ip,
                  input  ack, dest_ip, src_mac, dest_mac, forward_port);
  modport slave  (input  req, search_ip,
                  output ack, dest_ip, src_mac, dest_mac, forward_port);
endinterface

// File: rtl/router_out_mux.sv
// Steers the router's single write stream to one egress FIFO and returns
// that FIFO's full/half flags.
//   sel        : selected destination (NONE reports full/half so nothing writes)
//   wr_en/din  : write stream from the FSM
//   port_*     : egress FIFOs 0..3, nic_* : host FIFO
//   sel_full/sel_half : flags of the selected destination
module router_out_mux
  import router_pkg::*;
(
  input  dest_t            sel,
  input  logic             wr_en,
  input  logic [8:0]       din,
  input  logic [3:0]       port_full,
  input  logic [3:0]       port_half,
  output logic [3:0]       port_wr_en,
  output logic [3:0][8:0]  port_din,
  input  logic             nic_full,
  input  logic             nic_half,
  output logic             nic_wr_en,
  output logic [8:0]       nic_din,
  output logic             sel_full,
  output logic             sel_half
);

  always_comb begin
    port_wr_en = '0;
    port_din   = '0;
    nic_wr_en  = 1'b0;
    nic_din    = '0;
    sel_full   = 1'b1;
    sel_half   = 1'b1;
    case (sel)
      PORT0, PORT1, PORT2, PORT3: begin
        port_wr_en[sel[1:0]] = wr_en;
        port_din[sel[1:0]]   = wr_en ? din : 9'h000;
        sel_full             = port_full[sel[1:0]];
        sel_half             = port_half[sel[1:0]];
      end
      NIC: begin
        nic_wr_en = wr_en;
        nic_din   = wr_en ? din : 9'h000;
        sel_full  = nic_full;
        sel_half  = nic_half;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ipv4_router.sv
// Per-ingress-port IPv4 forwarding engine: RX FIFO -> header parse -> FIB
// lookup -> MAC rewrite -> one of four egress FIFOs or the host (NIC) FIFO.
// Optional build macro ROUTER_TTL_DEC_EN: routed frames get TTL-1 and an
// incrementally updated checksum; frames arriving with TTL <= 1 go to the NIC.
// Ports:
//   sys_clk, sys_rst (sync, active high), int_ipv4addr
//   dout/empty/rd_en            : RX FIFO (first-word fall-through)
//   portN_din/full/half/wr_en   : egress FIFOs, N = 0..3
//   nic_din/full/half/wr_en     : host FIFO
//   fib                         : FIB lookup handshake (master)
//
// state  | meaning
// SYNC   | discard until end of a frame (entered from reset)
// IDLE   | wait for first byte of a frame
// HDR    | pop 34 header bytes into hdr
// LOOKUP | req high, wait for FIB ack
// WAIT   | wait for the destination to drop half
// EMIT   | write the (rewritten) header
// BODY   | pass payload through, then terminator
// DROP   | pop to end of frame, no writes
module ipv4_router
  import router_pkg::*;
#(
  parameter logic [1:0] Port    = 2'h0,
  parameter logic [1:0] MaxPort = 2'h1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] int_ipv4addr,
  input  logic [8:0]  dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [8:0]  port0_din,
  input  logic        port0_full,
  input  logic        port0_half,
  output logic        port0_wr_en,
  output logic [8:0]  port1_din,
  input  logic        port1_full,
  input  logic        port1_half,
  output logic        port1_wr_en,
  output logic [8:0]  port2_din,
  input  logic        port2_full,
  input  logic        port2_half,
  output logic        port2_wr_en,
  output logic [8:0]  port3_din,
  input  logic        port3_full,
  input  logic        port3_half,
  output logic        port3_wr_en,
  output logic [8:0]  nic_din,
  input  logic        nic_full,
  input  logic        nic_half,
  output logic        nic_wr_en,
  ipv4_router_if.master fib
);

  state_t            state;
  dest_t             dest;
  logic [5:0]        cnt;
  logic [7:0]        hdr [HDR_LEN];
  logic              pop, wr, sel_full, sel_half;
  logic [8:0]        wdata;
  logic [31:0]       dip;
  logic              to_nic, ttl_expired;
  logic [3:0][8:0]   pdin;
  logic [3:0]        pwr;

  // The last DIP byte is still on dout when the forwarding decision is made.
  assign dip = {hdr[OFF_DIP], hdr[OFF_DIP+1], hdr[OFF_DIP+2], dout[7:0]};

`ifdef ROUTER_TTL_DEC_EN
  assign ttl_expired = (hdr[OFF_TTL] <= 8'd1);
`else
  assign ttl_expired = 1'b0;
`endif

  assign to_nic = ({hdr[OFF_TYPE], hdr[OFF_TYPE+1]} != ETHERTYPE_IPV4)
               || (hdr[OFF_VER][7:4] != 4'd4)
               || (dip == int_ipv4addr)
               || ({hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]} == 48'hffff_ffff_ffff)
               || ttl_expired;

  // Pop and write strobes depend on FIFO flags in the same cycle, so they are
  // decoded from the registered state rather than registered themselves.
  always_comb begin
    pop   = 1'b0;
    wr    = 1'b0;
    wdata = '0;
    if (!sys_rst) begin
      case (state)
        SYNC, HDR, DROP: pop = !empty;
        IDLE:            pop = !empty && !dout[8];
        EMIT: begin
          wr    = !sel_full;
          wdata = {1'b1, hdr[cnt]};
        end
        BODY: begin
          pop   = !empty && !sel_full;
          wr    = pop;
          wdata = dout[8] ? dout : 9'h000;
        end
        default: ;
      endcase
    end
  end

  assign rd_en = pop;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= SYNC;
      dest          <= NONE;
      cnt           <= '0;
      fib.req       <= 1'b0;
      fib.search_ip <= '0;
    end else begin
      case (state)
        SYNC: if (pop && !dout[8]) state <= IDLE;
        IDLE: if (!empty && dout[8]) begin
          state <= HDR;
          cnt   <= '0;
        end
        HDR: if (pop) begin
          if (!dout[8]) begin
            state <= IDLE;
          end else begin
            hdr[cnt] <= dout[7:0];
            cnt      <= cnt + 6'd1;
            if (cnt == 6'(HDR_LEN - 1)) begin
              cnt <= '0;
              if (to_nic) begin
                dest  <= NIC;
                state <= WAIT;
              end else begin
                fib.req       <= 1'b1;
                fib.search_ip <= dip;
                state         <= LOOKUP;
              end
            end
          end
        end
        LOOKUP: if (fib.ack) begin
          fib.req <= 1'b0;
          if (fib.forward_port == FIB_NO_ROUTE) begin
            dest  <= NIC;
            state <= WAIT;
          end else if (fib.forward_port > {2'b00, MaxPort} ||
                       fib.forward_port == {2'b00, Port}) begin
            state <= DROP;
          end else begin
            dest  <= dest_t'({1'b0, fib.forward_port[1:0]});
            state <= WAIT;
            // MACs are rewritten in the header buffer so EMIT replays it as-is.
            for (int i = 0; i < 6; i++) begin
              hdr[OFF_DMAC+i] <= fib.dest_mac[8*(5-i) +: 8];
              hdr[OFF_SMAC+i] <= fib.src_mac[8*(5-i) +: 8];
            end
`ifdef ROUTER_TTL_DEC_EN
            hdr[OFF_TTL] <= hdr[OFF_TTL] - 8'd1;
            {hdr[OFF_CSUM], hdr[OFF_CSUM+1]} <=
              csum_ttl_dec({hdr[OFF_CSUM], hdr[OFF_CSUM+1]});
`endif
          end
        end
        WAIT: if (!sel_half) state <= EMIT;
        EMIT: if (wr) begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(HDR_LEN - 1)) state <= BODY;
        end
        BODY: if (pop && !dout[8]) begin
          state <= IDLE;
          dest  <= NONE;
        end
        DROP: if (pop && !dout[8]) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end

  router_out_mux u_out_mux (
    .sel        (dest),
    .wr_en      (wr),
    .din        (wdata),
    .port_full  ({port3_full, port2_full, port1_full, port0_full}),
    .port_half  ({port3_half, port2_half, port1_half, port0_half}),
    .port_wr_en (pwr),
    .port_din   (pdin),
    .nic_full   (nic_full),
    .nic_half   (nic_half),
    .nic_wr_en  (nic_wr_en),
    .nic_din    (nic_din),
    .sel_full   (sel_full),
    .sel_half   (sel_half)
  );

  assign {port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en} = pwr;
  assign port0_din = pdin[0];
  assign port1_din = pdin[1];
  assign port2_din = pdin[2];
  assign port3_din = pdin[3];

endmodule

// File: tb/tb_ipv4_router.sv
// Directed self-checking bench for ipv4_router (Port=0, MaxPort=1,
// int_ipv4addr=10.0.21.1). Models the RX FIFO as a preloaded array and
// records every egress write per destination.
module tb_ipv4_router;
  import router_pkg::*;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst;
  logic [31:0] int_ipv4addr;
  logic [8:0]  dout;
  logic        empty, rd_en;
  logic [8:0]  port0_din, port1_din, port2_din, port3_din, nic_din;
  logic        port0_full, port1_full, port2_full, port3_full, nic_full;
  logic        port0_half, port1_half, port2_half, port3_half, nic_half;
  logic        port0_wr_en, port1_wr_en, port2_wr_en, port3_wr_en, nic_wr_en;

  ipv4_router_if fib();

  ipv4_router #(.Port(2'h0), .MaxPort(2'h1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .int_ipv4addr(int_ipv4addr),
    .dout(dout), .empty(empty), .rd_en(rd_en),
    .port0_din(port0_din), .port0_full(port0_full), .port0_half(port0_half), .port0_wr_en(port0_wr_en),
    .port1_din(port1_din), .port1_full(port1_full), .port1_half(port1_half), .port1_wr_en(port1_wr_en),
    .port2_din(port2_din), .port2_full(port2_full), .port2_half(port2_half), .port2_wr_en(port2_wr_en),
    .port3_din(port3_din), .port3_full(port3_full), .port3_half(port3_half), .port3_wr_en(port3_wr_en),
    .nic_din(nic_din), .nic_full(nic_full), .nic_half(nic_half), .nic_wr_en(nic_wr_en),
    .fib(fib)
  );

  // RX FIFO model
  logic [8:0] rx_mem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);
  assign dout  = rx_mem[rd_ptr[11:0]];

  // Egress capture: index 0..3 = ports, 4 = NIC
  logic [8:0] cap [5][1024];
  int   cap_n [5] = '{0, 0, 0, 0, 0};
  int   viol = 0;
  int   req_rises = 0;
  logic req_q = 1'b0;
  logic [4:0] w_en, w_full;
  logic [8:0] w_din [5];
  assign w_en   = {nic_wr_en, port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};
  assign w_full = {nic_full, port3_full, port2_full, port1_full, port0_full};
  assign w_din[0] = port0_din;
  assign w_din[1] = port1_din;
  assign w_din[2] = port2_din;
  assign w_din[3] = port3_din;
  assign w_din[4] = nic_din;

  always @(posedge sys_clk) begin
    for (int d = 0; d < 5; d++) begin
      if (w_en[d]) begin
        cap[d][cap_n[d][9:0]] <= w_din[d];
        cap_n[d] <= cap_n[d] + 1;
      end
    end
    if (rd_en) rd_ptr <= rd_ptr + 1;
    if ((w_en & w_full) != 5'b0 || (rd_en && empty)) viol <= viol + 1;
    req_q <= fib.req;
    if (fib.req && !req_q) req_rises <= req_rises + 1;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] fr [128];
  logic [7:0] ex [128];
  int flen;
  int base, r0, tot0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int total_wr();
    return cap_n[0] + cap_n[1] + cap_n[2] + cap_n[3] + cap_n[4];
  endfunction

  task automatic build(input logic [47:0] dm, input logic [15:0] et,
                       input logic [31:0] dip, input int plen, input logic [7:0] seed);
    for (int i = 0; i < 6; i++) begin
      fr[i]   = dm[8*(5-i) +: 8];
      fr[6+i] = 8'h10 + 8'(i);
    end
    fr[12] = et[15:8];
    fr[13] = et[7:0];
    fr[14] = 8'h45;
    for (int i = 15; i < 34; i++) fr[i] = seed + 8'(i);
    fr[22] = 8'h40;
    fr[24] = 8'h12;
    fr[25] = 8'h34;
    for (int i = 0; i < 4; i++) fr[30+i] = dip[8*(3-i) +: 8];
    for (int i = 0; i < plen; i++) fr[34+i] = seed ^ 8'(i * 3);
    flen = 34 + plen;
    for (int i = 0; i < flen; i++) ex[i] = fr[i];
  endtask

  // Routed: MACs replaced; with TTL decrement, TTL 0x40 -> 0x3f and csum as given.
  task automatic expect_routed(input logic [15:0] csum_dec);
    logic [47:0] dm, sm;
    dm = 48'h0011_2233_4455;
    sm = 48'h00a0_de1c_07e8;
    for (int i = 0; i < 6; i++) begin
      ex[i]   = dm[8*(5-i) +: 8];
      ex[6+i] = sm[8*(5-i) +: 8];
    end
`ifdef ROUTER_TTL_DEC_EN
    ex[22] = 8'h3f;
    ex[24] = csum_dec[15:8];
    ex[25] = csum_dec[7:0];
`else
    if (csum_dec == 16'h0) ex[22] = fr[22];
`endif
  endtask

  task automatic push();
    for (int i = 0; i < flen; i++) begin
      rx_mem[wr_ptr[11:0]] = {1'b1, fr[i]};
      wr_ptr++;
    end
    rx_mem[wr_ptr[11:0]] = 9'h000;
    wr_ptr++;
  endtask

  task automatic fib_answer(input logic [3:0] port, input logic [31:0] exp_ip, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (fib.req) begin ok = 1'b1; break; end
    end
    chk({tag, " req seen"}, 64'(ok), 64'd1);
    if (ok) begin
      chk({tag, " search_ip"}, 64'(fib.search_ip), 64'(exp_ip));
      fib.forward_port = port;
      fib.dest_mac     = 48'h0011_2233_4455;
      fib.src_mac      = 48'h00a0_de1c_07e8;
      fib.dest_ip      = exp_ip;
      fib.ack          = 1'b1;
      @(negedge sys_clk);
      fib.ack = 1'b0;
      chk({tag, " req dropped"}, 64'(fib.req), 64'd0);
      chk({tag, " ip held"}, 64'(fib.search_ip), 64'(fib.dest_ip));
    end
  endtask

  task automatic check_out(input int d, input int b, input string tag);
    bit ok = 1'b0;
    int idx;
    for (int i = 0; i < 1000; i++) begin
      if (cap_n[d] >= b + flen + 1) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk({tag, " frame complete"}, 64'(ok), 64'd1);
    if (ok) begin
      for (int i = 0; i < flen; i++) begin
        idx = b + i;
        chk({tag, " byte"}, 64'(cap[d][idx[9:0]]), 64'({1'b1, ex[i]}));
      end
      idx = b + flen;
      chk({tag, " terminator"}, 64'(cap[d][idx[9:0]]), 64'h0);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (empty) begin ok = 1'b1; break; end
    end
    chk({tag, " rx drained"}, 64'(ok), 64'd1);
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic wait_count(input int d, input int n, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (cap_n[d] >= n) begin ok = 1'b1; break; end
    end
    chk({tag, " mid-body reached"}, 64'(ok), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rx_mem[i] = 9'h000;
    sys_rst = 1'b1;
    int_ipv4addr = 32'h0a00_1501;
    {port0_full, port1_full, port2_full, port3_full, nic_full} = '0;
    {port0_half, port1_half, port2_half, port3_half, nic_half} = '0;
    fib.ack = 1'b0;
    fib.dest_ip = '0;
    fib.src_mac = '0;
    fib.dest_mac = '0;
    fib.forward_port = '0;
    repeat (3) @(negedge sys_clk);

    chk("reset rd_en", 64'(rd_en), 64'd0);
    chk("reset req", 64'(fib.req), 64'd0);
    chk("reset search_ip", 64'(fib.search_ip), 64'd0);
    chk("reset wr_en", 64'(w_en), 64'd0);
    chk("reset din", 64'({port0_din, port1_din, port2_din, port3_din, nic_din}), 64'd0);
    sys_rst = 1'b0;

    // SYNC needs an end-of-frame marker before the first real frame
    flen = 0;
    push();
    wait_drain("sync");

    // 1: routed IPv4 frame to port 1
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1605, 12, 8'h30);
    expect_routed(16'h1334);
    base = cap_n[1]; r0 = req_rises; tot0 = cap_n[4];
    push();
    fib_answer(4'h1, 32'h0a00_1605, "t1");
    check_out(1, base, "t1");
    chk("t1 single req", 64'(req_rises - r0), 64'd1);
    chk("t1 nic untouched", 64'(cap_n[4] - tot0), 64'd0);

    // 2: DIP is our own address -> NIC, unmodified, no lookup
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1501, 8, 8'h50);
    base = cap_n[4]; r0 = req_rises;
    push();
    check_out(4, base, "t2");
    chk("t2 no req", 64'(req_rises - r0), 64'd0);

    // 3: broadcast ARP -> NIC; held off while nic_half is high
    nic_half = 1'b1;
    build(48'hffff_ffff_ffff, 16'h0806, 32'h0a00_0001, 10, 8'h70);
    base = cap_n[4]; r0 = req_rises;
    push();
    repeat (80) @(negedge sys_clk);
    chk("t3 held by half", 64'(cap_n[4] - base), 64'd0);
    nic_half = 1'b0;
    check_out(4, base, "t3");
    chk("t3 no req", 64'(req_rises - r0), 64'd0);

    // 4: route back to ingress port -> dropped
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_0909, 8, 8'h90);
    tot0 = total_wr();
    push();
    fib_answer(4'h0, 32'h0a00_0909, "t4 hairpin");
    wait_drain("t4 hairpin");
    chk("t4 hairpin no writes", 64'(total_wr() - tot0), 64'd0);

    // 4b: port above MaxPort -> dropped
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_0a0a, 5, 8'h91);
    push();
    fib_answer(4'h2, 32'h0a00_0a0a, "t4 maxport");
    wait_drain("t4 maxport");
    chk("t4 maxport no writes", 64'(total_wr() - tot0), 64'd0);

    // 4c: runt frame (20 bytes) -> dropped, no lookup
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_0b0b, 0, 8'h92);
    flen = 20;
    r0 = req_rises;
    push();
    wait_drain("t4 runt");
    chk("t4 runt no writes", 64'(total_wr() - tot0), 64'd0);
    chk("t4 runt no req", 64'(req_rises - r0), 64'd0);

    // 4d: no route (4'hF) -> NIC unmodified
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_0c0c, 4, 8'h93);
    base = cap_n[4];
    push();
    fib_answer(4'hF, 32'h0a00_0c0c, "t4 noroute");
    check_out(4, base, "t4 noroute");

    // 4e: next valid frame routed normally
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1605, 6, 8'hb0);
    expect_routed(16'h1334);
    base = cap_n[1];
    push();
    fib_answer(4'h1, 32'h0a00_1605, "t4 next");
    check_out(1, base, "t4 next");

    // 5: port1_full for 5 cycles mid-body; checksum carry wraps (ff50 -> 0051)
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1605, 60, 8'hc0);
    fr[24] = 8'hff; fr[25] = 8'h50;
    ex[24] = 8'hff; ex[25] = 8'h50;
    expect_routed(16'h0051);
    base = cap_n[1];
    push();
    fib_answer(4'h1, 32'h0a00_1605, "t5");
    wait_count(1, base + 45, "t5");
    port1_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5 wr_en while full", 64'(port1_wr_en), 64'd0);
      chk("t5 rd_en while full", 64'(rd_en), 64'd0);
      @(negedge sys_clk);
    end
    port1_full = 1'b0;
    check_out(1, base, "t5");

    // 6: reset mid-body, rest of frame discarded, next frame routed
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1605, 60, 8'hd0);
    base = cap_n[1];
    push();
    fib_answer(4'h1, 32'h0a00_1605, "t6a");
    wait_count(1, base + 40, "t6");
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("t6 rst rd_en", 64'(rd_en), 64'd0);
    chk("t6 rst wr_en", 64'(w_en), 64'd0);
    chk("t6 rst port1_din", 64'(port1_din), 64'd0);
    chk("t6 rst req", 64'(fib.req), 64'd0);
    chk("t6 rst search_ip", 64'(fib.search_ip), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    base = cap_n[1];
    build(48'h0200_0000_0001, 16'h0800, 32'h0a00_1605, 10, 8'he0);
    expect_routed(16'h1334);
    push();
    fib_answer(4'h1, 32'h0a00_1605, "t6b");
    check_out(1, base, "t6b");

    chk("flow-control violations", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
